seg7_seq_checker: RTL

- Receive-side monitor for the active-low 7-segment bus driven by the wrapping digit counter.
- Samples segment lines on a strobe and decodes each pattern back to a digit code.
- Locks onto the counting sequence (0..9, then a run of blank frames, then 0) and flags every sequence violation.
- Sits on the display pins, or inside the test harness, as a self-check for the display path.

---
 rtl/seg7_seq_checker.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seg7_seq_checker.sv
// Receive-side monitor for an active-low 7-segment digit counter bus.
// Decodes strobed frames and checks the 0..9 / blank-run / 0 sequence.
module seg7_seq_checker #(
  parameter int BLANK_RUN = 6,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_n,
  input  logic             sample_en,
  input  logic             clr_err,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             locked,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {HUNT, DIGITS, BLANKS} state_t;

  localparam logic [3:0]       CODE_BLANK = 4'hE;
  localparam logic [3:0]       CODE_BAD   = 4'hF;
  localparam logic [ERR_W-1:0] ERR_ONE    = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       RUN_LEN    = 8'(BLANK_RUN);

  function automatic logic [3:0] seg_decode(input logic [6:0] s);
    logic [3:0] c;
    case (s)
      7'h40:   c = 4'd0;
      7'h79:   c = 4'd1;
      7'h24:   c = 4'd2;
      7'h30:   c = 4'd3;
      7'h19:   c = 4'd4;
      7'h12:   c = 4'd5;
      7'h02:   c = 4'd6;
      7'h78:   c = 4'd7;
      7'h00:   c = 4'd8;
      7'h10:   c = 4'd9;
      7'h7F:   c = CODE_BLANK;
      default: c = CODE_BAD;
    endcase
    return c;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + ERR_ONE;
  endfunction

  state_t     state, state_nx;
  logic [3:0] exp_q, exp_nx;
  logic [7:0] bcnt, bcnt_nx;
  logic       err_nx;
  logic [3:0] code_p0;

  assign code_p0 = seg_decode(seg_n);

  always_comb begin
    state_nx = state;
    exp_nx   = exp_q;
    bcnt_nx  = bcnt;
    err_nx   = 1'b0;
    if (sample_en) begin
      case (state)
        HUNT: begin
          if (code_p0 == 4'd0) begin
            state_nx = DIGITS;
            exp_nx   = 4'd1;
          end
        end
        DIGITS: begin
          if (code_p0 == exp_q) begin
            if (exp_q != 4'd9) begin
              exp_nx = exp_q + 4'd1;
            end else if (BLANK_RUN > 0) begin
              state_nx = BLANKS;
              bcnt_nx  = 8'd0;
            end else begin
              exp_nx = 4'd0;
            end
          end else if (code_p0 == 4'd0) begin
            // A stray 0 is treated as the counter restarting: resync in place.
            err_nx = 1'b1;
            exp_nx = 4'd1;
          end else begin
            err_nx   = 1'b1;
            state_nx = HUNT;
          end
        end
        BLANKS: begin
          if (code_p0 == CODE_BLANK) begin
            if ({1'b0, bcnt} + 9'd1 <= {1'b0, RUN_LEN}) begin
              bcnt_nx = bcnt + 8'd1;
            end else begin
              err_nx   = 1'b1;
              state_nx = HUNT;
            end
          end else if (code_p0 == 4'd0) begin
            err_nx   = (bcnt != RUN_LEN);
            state_nx = DIGITS;
            exp_nx   = 4'd1;
          end else begin
            err_nx   = 1'b1;
            state_nx = HUNT;
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  // Frame sampled in cycle T is reflected on every output at the T+1 edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      exp_q       <= 4'd0;
      bcnt        <= 8'd0;
      digit       <= CODE_BAD;
      digit_valid <= 1'b0;
      seq_err     <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_nx;
      exp_q       <= exp_nx;
      bcnt        <= bcnt_nx;
      digit_valid <= sample_en;
      seq_err     <= err_nx;
      if (sample_en) digit <= code_p0;
      if (clr_err)     err_count <= '0;
      else if (err_nx) err_count <= sat_inc(err_count);
    end
  end

  assign locked = (state != HUNT);

endmodule
